// File: rtl/multiplier_16bit.sv
// Sequential signed Q2.13 multiplier: radix-4 Booth, 4 partial products per cycle.
// Define MUL16_SAT_EN to saturate overflowing products instead of wrapping.
module multiplier_16bit (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_VLD,
  input  logic [15:0] I_M1,
  input  logic [15:0] I_M2,
  output logic        O_VLD,
  output logic        O_MUL_BUSY,
  output logic [15:0] O_PRODUCT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] m1_q, m1_d;
  logic [15:0] m2_q, m2_d;
  logic [31:0] acc_q, acc_d;
  logic        vld_q, vld_d;
  logic [15:0] prod_q, prod_d;

  logic        load;
  logic        add_en;
  logic        hi_sel;
  logic        fin;

  logic [16:0] m2x;
  logic [2:0]  win;
  logic [4:0]  sh;
  logic [31:0] pp_sum;
  logic [15:0] slice;
  logic        unused_bits;

  function automatic logic [31:0] booth_pp(
    input logic [15:0] m,
    input logic [2:0]  w,
    input logic [4:0]  s
  );
    logic [31:0] mx;
    logic [31:0] pp;
    mx = {{16{m[15]}}, m};
    case (w)
      3'b001, 3'b010: pp = mx;
      3'b011:         pp = mx << 1;
      3'b100:         pp = -(mx << 1);
      3'b101, 3'b110: pp = -mx;
      default:        pp = '0;
    endcase
    return pp << s;
  endfunction

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (I_VLD) state_d = ACC0;
      ACC0:    state_d = ACC1;
      ACC1:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    add_en = 1'b0;
    hi_sel = 1'b0;
    fin    = 1'b0;
    unique case (state_q)
      IDLE:    load = I_VLD;
      ACC0:    add_en = 1'b1;
      ACC1: begin
        add_en = 1'b1;
        hi_sel = 1'b1;
      end
      DONE:    fin = 1'b1;
      default: ;
    endcase
  end

  // Booth digit k of the selected half uses window m2[2i+1:2i-1], i = k or k+4.
  assign m2x = {m2_q, 1'b0};

  always_comb begin
    pp_sum = '0;
    win    = '0;
    sh     = '0;
    for (int k = 0; k < 4; k++) begin
      win    = hi_sel ? m2x[2*k+8 +: 3] : m2x[2*k +: 3];
      sh     = hi_sel ? 5'(2*k+8) : 5'(2*k);
      pp_sum = pp_sum + booth_pp(m1_q, win, sh);
    end
  end

  always_comb begin
`ifdef MUL16_SAT_EN
    if (acc_q[31:28] != {4{acc_q[31]}})
      slice = acc_q[31] ? 16'h8000 : 16'h7FFF;
    else
      slice = {acc_q[31], acc_q[27:13]};
`else
    slice = {acc_q[31], acc_q[27:13]};
`endif
  end

  assign unused_bits = ^{acc_q[30:28], acc_q[12:0]};

  always_comb begin
    m1_d   = m1_q;
    m2_d   = m2_q;
    acc_d  = acc_q;
    vld_d  = fin;
    prod_d = fin ? slice : 16'h0000;
    if (load) begin
      m1_d  = I_M1;
      m2_d  = I_M2;
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + pp_sum;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      m1_q   <= '0;
      m2_q   <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      prod_q <= prod_d;
    end
  end

  assign O_VLD      = vld_q;
  assign O_PRODUCT  = prod_q;
  assign O_MUL_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_multiplier_16bit.sv
// Bench for multiplier_16bit: directed vectors, busy/reset corner cases,
// back-to-back and random operands against an arithmetic reference.
module tb_multiplier_16bit;

  logic        clk;
  logic        rst;
  logic        i_vld;
  logic [15:0] i_m1;
  logic [15:0] i_m2;
  logic        o_vld;
  logic        o_busy;
  logic [15:0] o_prod;

  int checks = 0;
  int errors = 0;

  multiplier_16bit dut (
    .I_CLK      (clk),
    .I_RST      (rst),
    .I_VLD      (i_vld),
    .I_M1       (i_m1),
    .I_M2       (i_m2),
    .O_VLD      (o_vld),
    .O_MUL_BUSY (o_busy),
    .O_PRODUCT  (o_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int     pa, pb;
    longint p, q;
    logic [15:0] r;
    pa = int'($signed(a));
    pb = int'($signed(b));
    p  = longint'(pa) * longint'(pb);
    q  = p >>> 13;
`ifdef MUL16_SAT_EN
    if (q > 32767)       r = 16'h7FFF;
    else if (q < -32768) r = 16'h8000;
    else                 r = q[15:0];
`else
    r = {p < 0, q[14:0]};
`endif
    return r;
  endfunction

  // Presents one operand pair for a single edge; returns #1 after that edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    i_vld = 1'b1;
    i_m1  = a;
    i_m2  = b;
    @(posedge clk);
    #1;
    i_vld = 1'b0;
    i_m1  = 16'($urandom);
    i_m2  = 16'($urandom);
  endtask

  // Counts edges until O_VLD is seen (bounded); lat=99 if it never comes.
  task automatic wait_vld(output int lat);
    lat = 0;
    while (!o_vld && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!o_vld) lat = 99;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    i_vld = 1'b0;
    i_m1  = 16'h1234;
    i_m2  = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_vld, o_busy, o_prod} !== 18'h0) begin
      errors++;
      $display("FAIL reset_hold vld=%b busy=%b prod=%h required 0/0/0000", o_vld, o_busy, o_prod);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_vld, o_busy, o_prod} !== 18'h0) begin
      errors++;
      $display("FAIL reset_release vld=%b busy=%b prod=%h required 0/0/0000", o_vld, o_busy, o_prod);
    end
  endtask

  task automatic test_directed;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [15:0] ve [6];
    int lat;
    va = '{16'h2000, 16'hE000, 16'h1000, 16'h0001, 16'hFFFF, 16'h8000};
    vb = '{16'h2000, 16'h2000, 16'hC000, 16'h0001, 16'h0001, 16'h8000};
`ifdef MUL16_SAT_EN
    ve = '{16'h2000, 16'hE000, 16'hE000, 16'h0000, 16'hFFFF, 16'h7FFF};
`else
    ve = '{16'h2000, 16'hE000, 16'hE000, 16'h0000, 16'hFFFF, 16'h0000};
`endif
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i]);
      checks++;
      if (o_busy !== 1'b1 || o_vld !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_start busy=%b vld=%b required 1/0", i, o_busy, o_vld);
      end
      wait_vld(lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d required 3", i, lat);
      end
      checks++;
      if (o_prod !== ve[i] || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_product %h*%h got %h busy=%b required %h busy=0",
                 i, va[i], vb[i], o_prod, o_busy, ve[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_vld !== 1'b0 || o_prod !== 16'h0) begin
        errors++;
        $display("FAIL dir%0d_clear vld=%b prod=%h required 0/0000", i, o_vld, o_prod);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra;
    issue(16'h2000, 16'hE000);
    issue(16'h7FFF, 16'h7FFF);
    wait_vld(lat);
    checks++;
    if (lat !== 2 || o_prod !== 16'hE000) begin
      errors++;
      $display("FAIL busy_ignore lat=%0d prod=%h required lat 2 prod e000", lat, o_prod);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (o_vld) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_ignore_extra got %0d extra pulses required 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int pulses;
    issue(16'h2000, 16'h2000);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_vld, o_busy, o_prod} !== 18'h0) begin
      errors++;
      $display("FAIL abort_async vld=%b busy=%b prod=%h required 0/0/0000", o_vld, o_busy, o_prod);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (o_vld || o_busy || o_prod != 16'h0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles required 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, exp;
    int lat;
    a = 16'($urandom);
    b = 16'($urandom);
    issue(a, b);
    for (int n = 0; n < 500; n++) begin
      exp = model(a, b);
      wait_vld(lat);
      checks++;
      if (lat !== 3 || o_prod !== exp || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_op%0d %h*%h lat=%0d prod=%h busy=%b required lat 3 prod %h busy 0",
                 n, a, b, lat, o_prod, o_busy, exp);
        break;
      end
      a = 16'($urandom);
      b = 16'($urandom);
      if (n < 499) issue(a, b);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [15:0] a, b, exp;
    int lat;
    for (int n = 0; n < 3000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 8 == 0) a = 16'($urandom_range(0, 3)) << 14;
      exp = model(a, b);
      issue(a, b);
      wait_vld(lat);
      checks++;
      if (lat !== 3 || o_prod !== exp) begin
        errors++;
        $display("FAIL rand_op%0d %h*%h lat=%0d prod=%h required lat 3 prod %h",
                 n, a, b, lat, o_prod, exp);
        break;
      end
      repeat ($urandom_range(2, 3)) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (o_vld !== 1'b0 || o_prod !== 16'h0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle%0d vld=%b prod=%h busy=%b required 0/0000/0",
                 n, o_vld, o_prod, o_busy);
        break;
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
